// File: rtl/spi_pkg.sv
// Shared definitions for the SD-card SPI byte engine and its clock divider.
// FSM encoding, SD idle byte and the default SCK half-period divider.
package spi_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_HOLD  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_SETUP = ST_SETUP,
    S_SHIFT = ST_SHIFT,
    S_DONE  = ST_DONE,
    S_HOLD  = ST_HOLD
  } state_t;

  localparam logic [7:0] SD_IDLE_BYTE    = 8'hFF;
  localparam int         DEFAULT_CLK_DIV = 6;

endpackage

// File: rtl/spi_byte_master_if.sv
// Byte-stream side of the SPI engine: tx valid/ready handshake, rx pulse and status.
// master = upstream byte producer/consumer, slave = the SPI engine.
interface spi_byte_master_if;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic       cs_hold;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       busy;

  modport master (
    output tx_valid, tx_data, cs_hold,
    input  tx_ready, rx_valid, rx_data, busy
  );

  modport slave (
    input  tx_valid, tx_data, cs_hold,
    output tx_ready, rx_valid, rx_data, busy
  );
endinterface

// File: rtl/spi_tick_div.sv
// 8-bit down-counter emitting a one-cycle tick every CLK_DIV clocks; clr restarts the period.
// First tick after clr arrives CLK_DIV cycles later; no backpressure.
module spi_tick_div
  import spi_pkg::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam logic [7:0] RELOAD = 8'(CLK_DIV - 1);

  logic [7:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= RELOAD;
    end else if (clr || cnt == 8'd0) begin
      cnt <= RELOAD;
    end else begin
      cnt <= cnt - 8'd1;
    end
  end

  assign tick = (cnt == 8'd0) && !clr;

endmodule

// File: rtl/spi_byte_master.sv
// SPI mode-0 full-duplex byte engine for the SD card; rx_valid 17*CLK_DIV cycles after accept.
// tx_ready only in IDLE or in DONE with cs_hold; offers while not ready are dropped.
module spi_byte_master
  import spi_pkg::*;
#(
  parameter int   CLK_DIV   = DEFAULT_CLK_DIV,
  parameter logic IDLE_MOSI = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  spi_byte_master_if.slave         bus,
  output logic                     sclk,
  output logic                     mosi,
  input  logic                     miso,
  output logic                     cs_n
);

  state_t     state, state_nxt;
  logic [7:0] sr, sr_nxt;
  logic [2:0] bit_cnt, bit_cnt_nxt;
  logic       last_lo, last_lo_nxt;
  logic [7:0] rx_data, rx_data_nxt;
  logic       sclk_nxt, mosi_nxt, cs_n_nxt;
  logic       tick, div_clr, tx_ready, accept;

  spi_tick_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (div_clr),
    .tick  (tick)
  );

  assign tx_ready = (state == S_IDLE) || (state == S_DONE && bus.cs_hold);
  assign accept   = bus.tx_valid && tx_ready;

  always_comb begin
    state_nxt   = state;
    sr_nxt      = sr;
    bit_cnt_nxt = bit_cnt;
    last_lo_nxt = last_lo;
    rx_data_nxt = rx_data;
    sclk_nxt    = sclk;
    mosi_nxt    = mosi;
    cs_n_nxt    = cs_n;
    div_clr     = 1'b0;

    // sr keeps the bits still to send in its top, leaving sr[0] free for the miso sample.
    if (accept) begin
      state_nxt   = S_SETUP;
      cs_n_nxt    = 1'b0;
      mosi_nxt    = bus.tx_data[7];
      sr_nxt      = {bus.tx_data[6:0], 1'b0};
      bit_cnt_nxt = 3'd7;
      last_lo_nxt = 1'b0;
      div_clr     = 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (!cs_n && !bus.cs_hold) state_nxt = S_HOLD;
        end
        S_SETUP: begin
          if (tick) begin
            sclk_nxt  = 1'b1;
            sr_nxt[0] = miso;
            state_nxt = S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (tick) begin
            if (last_lo) begin
              // final low phase has run a full half-period
              state_nxt   = S_DONE;
              last_lo_nxt = 1'b0;
              rx_data_nxt = sr;
              mosi_nxt    = IDLE_MOSI;
            end else if (sclk) begin
              sclk_nxt = 1'b0;
              if (bit_cnt == 3'd0) begin
                last_lo_nxt = 1'b1;
              end else begin
                mosi_nxt    = sr[7];
                sr_nxt      = {sr[6:0], 1'b0};
                bit_cnt_nxt = bit_cnt - 3'd1;
              end
            end else begin
              sclk_nxt  = 1'b1;
              sr_nxt[0] = miso;
            end
          end
        end
        S_DONE: begin
          state_nxt = bus.cs_hold ? S_IDLE : S_HOLD;
        end
        S_HOLD: begin
          if (tick) begin
            cs_n_nxt  = 1'b1;
            state_nxt = S_IDLE;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      sr      <= 8'h00;
      bit_cnt <= 3'd0;
      last_lo <= 1'b0;
      rx_data <= 8'h00;
      sclk    <= 1'b0;
      mosi    <= IDLE_MOSI;
      cs_n    <= 1'b1;
    end else begin
      state   <= state_nxt;
      sr      <= sr_nxt;
      bit_cnt <= bit_cnt_nxt;
      last_lo <= last_lo_nxt;
      rx_data <= rx_data_nxt;
      sclk    <= sclk_nxt;
      mosi    <= mosi_nxt;
      cs_n    <= cs_n_nxt;
    end
  end

  assign bus.tx_ready = tx_ready;
  assign bus.rx_valid = (state == S_DONE);
  assign bus.rx_data  = rx_data;
  assign bus.busy     = !cs_n || (state != S_IDLE);

endmodule

// File: tb/tb_spi_byte_master.sv
// Directed bench for spi_byte_master: loopback, card model, back-to-back, busy rejection, mid-byte reset.
module tb_spi_byte_master;
  import spi_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic sclk, mosi, miso, cs_n;
  logic loop_mode;
  logic [7:0] slave_byte;
  logic [7:0] s_sr = 8'hFF;
  logic [7:0] mosi_rise = 8'h00;
  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  spi_byte_master_if bus();

  spi_byte_master #(.CLK_DIV(6), .IDLE_MOSI(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .sclk  (sclk),
    .mosi  (mosi),
    .miso  (miso),
    .cs_n  (cs_n)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // card model: MSB ready when selected, next bit after each falling SCK
  always @(negedge cs_n) s_sr = slave_byte;
  always @(negedge sclk) if (!cs_n) s_sr = {s_sr[6:0], 1'b1};
  always @(posedge sclk) mosi_rise = {mosi_rise[6:0], mosi};
  assign miso = loop_mode ? mosi : s_sr[7];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed running expected finished");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offer one byte (cs_hold=1 while offering), then set cs_hold and run until rx_valid.
  task automatic xfer(input logic [7:0] tx, input logic hold_after, input int poke_k,
                      output int lat, output logic [7:0] rx, output int sclk_err,
                      output int pulses, output int csn_hi);
    logic prev;
    logic exp_sclk;
    lat = -1; rx = 8'h00; sclk_err = 0; pulses = 0; csn_hi = 0;
    for (int w = 0; w < 60 && !bus.tx_ready; w++) step();
    bus.tx_data  = tx;
    bus.tx_valid = 1'b1;
    bus.cs_hold  = 1'b1;
    step();
    bus.tx_valid = 1'b0;
    bus.cs_hold  = hold_after;
    prev = sclk;
    for (int k = 1; k <= 200; k++) begin
      step();
      exp_sclk = (k < 96) && ((k / 6) % 2 == 1);
      if (sclk !== exp_sclk) sclk_err++;
      if (sclk && !prev) pulses++;
      prev = sclk;
      if (cs_n) csn_hi++;
      if (bus.rx_valid) begin
        lat = k;
        rx  = bus.rx_data;
        break;
      end
      if (k == poke_k) begin
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'h00;
        chk("busy_tx_ready", 32'(bus.tx_ready), 32'd0);
      end else begin
        bus.tx_valid = 1'b0;
      end
    end
    bus.tx_valid = 1'b0;
  endtask

  initial begin
    int lat, se, pl, ch, csn_tot, r1, r2, extra, w;
    logic [7:0] rx;

    rst_n = 1'b0; loop_mode = 1'b1; slave_byte = 8'h00;
    bus.tx_valid = 1'b0; bus.tx_data = 8'h00; bus.cs_hold = 1'b0;
    repeat (5) step();
    chk("rst_cs_n", 32'(cs_n), 32'd1);
    chk("rst_sclk", 32'(sclk), 32'd0);
    chk("rst_mosi", 32'(mosi), 32'd1);
    chk("rst_tx_ready", 32'(bus.tx_ready), 32'd1);
    chk("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
    chk("rst_rx_data", 32'(bus.rx_data), 32'h00);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    rst_n = 1'b1;
    step();

    // loopback A5
    xfer(8'hA5, 1'b0, -1, lat, rx, se, pl, ch);
    chk("lb_latency", lat, 102);
    chk("lb_rx_data", 32'(rx), 32'hA5);
    chk("lb_sclk_shape", se, 0);
    chk("lb_sclk_pulses", pl, 8);
    chk("lb_mosi_stream", 32'(mosi_rise), 32'hA5);
    step();
    chk("lb_rx_valid_pulse", 32'(bus.rx_valid), 32'd0);
    chk("lb_rx_data_held", 32'(bus.rx_data), 32'hA5);

    // card returns 3C while we send the idle byte
    loop_mode = 1'b0; slave_byte = 8'h3C;
    xfer(SD_IDLE_BYTE, 1'b0, -1, lat, rx, se, pl, ch);
    chk("sd_rx_data", 32'(rx), 32'h3C);
    chk("sd_mosi_high", 32'(mosi_rise), 32'hFF);
    chk("sd_latency", lat, 102);

    // back-to-back with cs_hold
    loop_mode = 1'b1;
    xfer(8'h40, 1'b1, -1, lat, rx, se, pl, ch);
    r1 = cyc; csn_tot = ch;
    chk("b2b_rx0", 32'(rx), 32'h40);
    xfer(8'h00, 1'b0, -1, lat, rx, se, pl, ch);
    r2 = cyc; csn_tot += ch;
    chk("b2b_rx1", 32'(rx), 32'h00);
    chk("b2b_cs_low", csn_tot, 0);
    chk("b2b_period", r2 - r1, 103);
    for (w = 0; w < 20 && !cs_n; w++) step();
    chk("b2b_cs_rise", cyc - r2, 6);

    // offer a byte mid-transfer: must be ignored
    xfer(8'hC3, 1'b0, 50, lat, rx, se, pl, ch);
    chk("rej_rx_data", 32'(rx), 32'hC3);
    chk("rej_mosi_stream", 32'(mosi_rise), 32'hC3);
    chk("rej_latency", lat, 102);
    extra = 0;
    for (int i = 0; i < 150; i++) begin
      step();
      if (bus.rx_valid) extra++;
    end
    chk("rej_no_extra", extra, 0);
    chk("rej_idle_busy", 32'(bus.busy), 32'd0);
    chk("rej_idle_cs_n", 32'(cs_n), 32'd1);

    // reset in the middle of bit 4
    bus.tx_data = 8'h5A; bus.tx_valid = 1'b1; bus.cs_hold = 1'b0;
    step();
    bus.tx_valid = 1'b0;
    repeat (45) step();
    chk("mid_sclk_before", 32'(sclk), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cs_n", 32'(cs_n), 32'd1);
    chk("mid_rst_sclk", 32'(sclk), 32'd0);
    chk("mid_rst_mosi", 32'(mosi), 32'd1);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    extra = 0;
    for (int i = 0; i < 110; i++) begin
      step();
      if (bus.rx_valid) extra++;
    end
    chk("mid_no_rx_valid", extra, 0);
    xfer(8'h96, 1'b0, -1, lat, rx, se, pl, ch);
    chk("post_rst_rx", 32'(rx), 32'h96);
    chk("post_rst_latency", lat, 102);
    chk("post_rst_sclk_shape", se, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
